byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter DATA_W, default 8, is the byte width; the only supported value is 8.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port data_in, input, DATA_W bits: parallel byte from the upstream register stage.
REQ-005 Port in_valid, input, 1 bit: data_in is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: the holding buffer is empty, so a byte can be accepted.
REQ-007 Port ser_out, output, 1 bit: serial data bit.
REQ-008 Port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-009 Port frame_start, output, 1 bit: high on the cycle that carries bit 0 of a frame.
REQ-010 Port busy, output, 1 bit: the FSM is not in IDLE, or the holding buffer is full.

Function
REQ-011 Handshake SHALL be: byte accepted on a rising edge where in_valid && in_ready; accepted byte written to a one-entry holding register; hold_full set.
REQ-012 in_ready SHALL equal !hold_full, derived only from registered state, with no combinational path from in_valid.
REQ-013 While in_valid is high and in_ready is low, upstream holds data_in stable; no capture occurs and no byte is dropped or duplicated.
REQ-014 FSM states SHALL be IDLE, SHIFT and PARITY (PARITY reachable only per REQ-024); encoding defined in ser_pkg.
REQ-015 IDLE -> SHIFT when hold_full: hold moves to the shift register, bit_cnt=0, hold_full cleared on the same edge.
REQ-016 Latency: handshake at edge N -> ser_valid and frame_start high after edge N+1 -> bit i presented after edge N+1+i.
REQ-017 Bit order SHALL be LSB first: the bit in cycle i is byte[i], i=0..7.
REQ-018 ser_out, ser_valid and frame_start SHALL be registered outputs.
REQ-019 ser_out SHALL be 0 whenever ser_valid is 0.
REQ-020 SHIFT with bit_cnt==7 and no parity: if hold_full, load next byte and stay in SHIFT (zero-gap frames); else -> IDLE.
REQ-021 A hold-to-shifter transfer and a new accept SHALL NOT occur on the same edge, because in_ready is low on that cycle.
REQ-022 bit_cnt SHALL be 3 bits and wrap 7 -> 0 only on a frame reload.

Reset
REQ-023 On reset assertion, asynchronously: state=IDLE, hold_full=0, bit_cnt=0, shift register=0, ser_out=0, ser_valid=0, frame_start=0, busy=0, in_ready=1.
- In-flight and held bytes are discarded.
- No residual bits are emitted after reset release.

Configuration
REQ-024 With SER_PARITY_EN defined:
- after bit 7, SHIFT -> PARITY for one cycle;
- ser_out = XOR of the 8 data bits (even parity), ser_valid=1, frame_start=0;
- PARITY -> SHIFT if hold_full (with reload), else -> IDLE;
- frame length is 9 cycles.
REQ-025 Without SER_PARITY_EN: no PARITY state logic is compiled; frame length is 8 cycles.

Structure
REQ-026 Package ser_pkg SHALL hold DATA_W_DEF=8, the state enum ser_state_t, and typedef byte_t (logic [7:0]).
REQ-027 The bit counter with its wrap/terminal flag SHALL be sub-module ser_bit_cnt; all other logic stays in byte_serializer.

Verification
REQ-028 Reset, then accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles; frame_start on the first only; busy falls after the last bit.
REQ-029 in_valid held high with 8'h01 then 8'hFF -> 16 contiguous ser_valid cycles; frame_start at cycles 0 and 8; in_ready low while hold_full.
REQ-030 SER_PARITY_EN defined, send 8'h07 -> 9-cycle frame, 9th bit 1; not defined -> 8-cycle frame, ser_valid low after bit 7.
REQ-031 Assert reset during bit 3 of 8'hC3 with 8'h3C held -> outputs 0 immediately, without waiting for a clock edge; after release in_ready=1; neither byte emitted.
REQ-032 Present 8'h55 with in_valid while in_ready=0, keep it held -> captured exactly once when in_ready rises; serialized once as 1,0,1,0,1,0,1,0.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared width, FSM state encoding and byte type for the byte serializer
package ser_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/ser_bit_cnt.sv
// ser_bit_cnt: 3-bit index of the frame bit on ser_out, with terminal flag at bit 7
// Ports: clk, reset (async, active-high), clr (frame load), inc (advance), cnt, last (cnt==7)
module ser_bit_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt,
  output logic       last
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 3'd1;
  assign last = cnt == 3'd7;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: one-entry buffered parallel-to-serial converter, LSB first, optional even parity
// Ports: clk, reset (async, active-high), data_in/in_valid/in_ready (upstream handshake),
//        ser_out/ser_valid/frame_start (registered serial stream), busy (FSM active or buffer full)
// Define SER_PARITY_EN to append an even-parity bit, making frames 9 cycles long.
module byte_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy
);
  ser_state_t state, nstate;
  logic [DATA_W-1:0] hold, sh;
  logic hold_full, load, inc, par_bit, last, n_out, n_valid, n_fs;
  logic [2:0] cnt, nxt;
  ser_bit_cnt u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(load),
    .inc(inc),
    .cnt(cnt),
    .last(last)
  );
  assign nxt = cnt + 3'd1;
  assign in_ready = !hold_full;
  assign busy = (state != IDLE) || hold_full;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nstate;
  // Outputs are precomputed here so ser_out/ser_valid/frame_start leave a flop;
  // sh keeps the whole byte, indexed by the next bit position (also feeds parity).
  always_comb begin
    nstate = state;
    load = 1'b0;
    inc = 1'b0;
    par_bit = 1'b0;
    case (state)
      SHIFT: begin
        inc = !last;
`ifdef SER_PARITY_EN
        par_bit = last;
        nstate = last ? PARITY : SHIFT;
`else
        load = last && hold_full;
        nstate = (last && !hold_full) ? IDLE : SHIFT;
`endif
      end
      default: begin
        load = hold_full;
        nstate = hold_full ? SHIFT : IDLE;
      end
    endcase
    n_valid = load || inc || par_bit;
    n_fs = load;
    n_out = load ? hold[0] : inc ? sh[nxt] : par_bit ? ^sh : 1'b0;
  end
  // A load only happens with hold_full set, so in_ready is low and no accept can collide.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_full <= 1'b0;
      hold <= '0;
      sh <= '0;
      ser_out <= 1'b0;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (load) hold_full <= 1'b0;
      else if (in_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold <= data_in;
      end
      if (load) sh <= hold;
      ser_out <= n_out;
      ser_valid <= n_valid;
      frame_start <= n_fs;
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: scoreboard bench for byte_serializer (directed bytes, bit-level checking)
module tb_byte_serializer;
`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic in_ready, ser_out, ser_valid, frame_start, busy;
  int checks = 0;
  int errors = 0;
  int run = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];

  byte_serializer dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push(logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 0, b[i]});
`ifdef SER_PARITY_EN
    exp_q.push_back({1'b0, ^b});
`endif
  endfunction

  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (ser_valid) begin
        run++;
        if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ser_out", ser_out, e[0]);
          check("frame_start", frame_start, e[1]);
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        check("idle_outputs", {frame_start, ser_out}, 0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input string nm);
    int n = 0;
    data_in = b;
    in_valid = 1'b1;
    push(b);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept_timeout"}, n < 100, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ser_valid || exp_q.size() != 0) && n < 200);
    check({nm, "_drain_timeout"}, n < 200, 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #15;
    check("rst_in_ready", in_ready, 1);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    // single byte: A5 -> 1,0,1,0,0,1,0,1
    send(8'hA5, "a5");
    check("a5_busy", busy, 1);
    wait_idle("a5");
    check("a5_len", last_run, FL);
    check("a5_busy_after", busy, 0);
    // 07: parity bit is 1 when enabled
    send(8'h07, "h07");
    wait_idle("h07");
    check("h07_len", last_run, FL);
    // back-to-back 01, FF with in_valid held
    send(8'h01, "h01");
    send(8'hFF, "hff");
    check("hff_in_ready_full", in_ready, 0);
    check("hff_busy", busy, 1);
    wait_idle("hff");
    check("b2b_len", last_run, 2 * FL);
    // 55 presented while in_ready low, must be taken once
    send(8'h0F, "h0f");
    send(8'hF0, "hf0");
    check("h55_in_ready_low", in_ready, 0);
    send(8'h55, "h55");
    wait_idle("h55");
    check("h55_len", last_run, 3 * FL);
    // reset in the middle of C3 with 3C held
    send(8'hC3, "hc3");
    data_in = 8'h3C;
    in_valid = 1'b1;
    n = 0;
    while (!frame_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hc3_start_timeout", n < 20, 1);
    repeat (3) @(negedge clk);
    check("hc3_bit3_valid", ser_valid, 1);
    check("hc3_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_ser_valid", ser_valid, 0);
    check("async_frame_start", frame_start, 0);
    check("async_ser_out", ser_out, 0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 1);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
